// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package irq_pkg;

  localparam int          IRQ_ID_W        = 5;
  localparam int          NUM_IRQ         = 32;
  localparam logic [31:0] VEC_ENTRY_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    REDIRECT,
    RETURN
  } irq_state_e;

  // Lowest index wins; an empty mask yields 0.
  function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] m);
    lowest_set = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IRQ_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_ctx_stack.sv
// LIFO of saved {pc, id} contexts for nested interrupt service.
module irq_ctx_stack
  import irq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int DW    = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [31:0]         push_pc,
  input  logic [IRQ_ID_W-1:0] push_id,
  input  logic                pop,
  output logic [31:0]         top_pc,
  output logic [IRQ_ID_W-1:0] top_id,
  output logic [DW-1:0]       depth,
  output logic                full,
  output logic                empty
);

  logic [31:0]         pc_q [DEPTH];
  logic [IRQ_ID_W-1:0] id_q [DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic [DW-1:0]       top_idx;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign top_idx = depth_q - DW'(1);

  // Entries carry no reset: depth alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      pc_q[depth_q[PW-1:0]] <= push_pc;
      id_q[depth_q[PW-1:0]] <= push_id;
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (push && !full)      depth_d = depth_q + DW'(1);
    else if (pop && !empty) depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  assign top_pc = empty ? '0 : pc_q[top_idx[PW-1:0]];
  assign top_id = empty ? '0 : id_q[top_idx[PW-1:0]];

endmodule

// File: rtl/irq_entry_sequencer.sv
// CPU-side interrupt entry/return sequencer: latches pending sources, stacks
// context, fetches the handler address and redirects the core.
module irq_entry_sequencer
  import irq_pkg::*;
#(
  parameter  logic [31:0] VTBL_BASE  = 32'h0000_0100,
  parameter  int          NEST_DEPTH = 4,
  localparam int          DW         = $clog2(NEST_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                irq_valid,
  input  logic [31:0]         irq_vector,
  input  logic                int_enable,
  input  logic                insn_boundary,
  input  logic [31:0]         cur_pc,
  input  logic                iret,
  output logic                vtbl_req,
  output logic [31:0]         vtbl_addr,
  input  logic                vtbl_ack,
  input  logic [31:0]         vtbl_data,
  output logic                stall_core,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic                in_service,
  output logic [IRQ_ID_W-1:0] active_irq,
  output logic [DW-1:0]       nest_depth,
  output logic                iret_err
);

  irq_state_e          state_q, state_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d, take_clr;
  logic [IRQ_ID_W-1:0] sel_q, sel_d, sel_id, top_id;
  logic [31:0]         handler_q, handler_d, top_pc;
  logic                iret_err_q, iret_err_d;
  logic                take, pop, full, empty, eligible;

  irq_ctx_stack #(.DEPTH(NEST_DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (take),
    .push_pc (cur_pc),
    .push_id (sel_id),
    .pop     (pop),
    .top_pc  (top_pc),
    .top_id  (top_id),
    .depth   (nest_depth),
    .full    (full),
    .empty   (empty)
  );

  assign sel_id   = lowest_set(pend_q);
  assign eligible = empty || (sel_id < top_id);

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
    assign take_clr[gi] = take && (sel_id == IRQ_ID_W'(gi));
  end

  // A new set of the bit being taken this cycle survives the clear.
  assign pend_d = (pend_q & ~take_clr) | (irq_valid ? irq_vector : '0);

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    handler_d      = handler_q;
    iret_err_d     = 1'b0;
    take           = 1'b0;
    pop            = 1'b0;
    vtbl_req       = 1'b0;
    vtbl_addr      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (iret) begin
          if (!empty) state_d    = RETURN;
          else        iret_err_d = 1'b1;
        end else if ((pend_q != '0) && int_enable && insn_boundary && eligible && !full) begin
          take    = 1'b1;
          sel_d   = sel_id;
          state_d = FETCH;
        end
      end
      FETCH: begin
        vtbl_req  = 1'b1;
        vtbl_addr = VTBL_BASE + 32'(sel_q) * VEC_ENTRY_BYTES;
        if (vtbl_ack) begin
          handler_d = vtbl_data & ~32'h3;
          state_d   = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = handler_q;
        state_d        = IDLE;
      end
      RETURN: begin
        redirect_valid = 1'b1;
        redirect_pc    = top_pc;
        pop            = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      sel_q      <= '0;
      handler_q  <= '0;
      iret_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      sel_q      <= sel_d;
      handler_q  <= handler_d;
      iret_err_q <= iret_err_d;
    end
  end

  assign stall_core = (state_q != IDLE);
  assign in_service = !empty;
  assign active_irq = top_id;
  assign iret_err   = iret_err_q;

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Directed self-checking bench for irq_entry_sequencer.
module tb_irq_entry_sequencer;

  logic        clk;
  logic        reset;
  logic        irq_valid;
  logic [31:0] irq_vector;
  logic        int_enable;
  logic        insn_boundary;
  logic [31:0] cur_pc;
  logic        iret;
  logic        vtbl_req;
  logic [31:0] vtbl_addr;
  logic        vtbl_ack;
  logic [31:0] vtbl_data;
  logic        stall_core;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_service;
  logic [4:0]  active_irq;
  logic [2:0]  nest_depth;
  logic        iret_err;

  int checks = 0;
  int errors = 0;

  irq_entry_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .irq_valid      (irq_valid),
    .irq_vector     (irq_vector),
    .int_enable     (int_enable),
    .insn_boundary  (insn_boundary),
    .cur_pc         (cur_pc),
    .iret           (iret),
    .vtbl_req       (vtbl_req),
    .vtbl_addr      (vtbl_addr),
    .vtbl_ack       (vtbl_ack),
    .vtbl_data      (vtbl_data),
    .stall_core     (stall_core),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .in_service     (in_service),
    .active_irq     (active_irq),
    .nest_depth     (nest_depth),
    .iret_err       (iret_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    irq_valid = 0; irq_vector = 0; int_enable = 0; insn_boundary = 0;
    cur_pc = 0; iret = 0; vtbl_ack = 0; vtbl_data = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic pulse_irq(input logic [31:0] v);
    irq_valid = 1; irq_vector = v;
    @(negedge clk);
    irq_valid = 0; irq_vector = 0;
  endtask

  // Waits (bounded) for a table read, answers it, and records what came out.
  task automatic fetch_ack(input logic [31:0] data, output bit got, output logic [31:0] addr,
                           output logic rv, output logic [31:0] rpc);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (vtbl_req === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    addr = vtbl_addr;
    rv = 0; rpc = 0;
    if (got) begin
      vtbl_ack = 1; vtbl_data = data;
      @(negedge clk);
      vtbl_ack = 0; vtbl_data = 0;
      rv = redirect_valid; rpc = redirect_pc;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (vtbl_req !== 1'b0) begin errors++; $display("FAIL reset_vtbl_req got %b exp 0", vtbl_req); end
    checks++; if (vtbl_addr !== 32'h0) begin errors++; $display("FAIL reset_vtbl_addr got %h exp 0", vtbl_addr); end
    checks++; if (stall_core !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_core); end
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %b/%h exp 0/0", redirect_valid, redirect_pc); end
    checks++; if (in_service !== 1'b0 || active_irq !== 5'd0 || nest_depth !== 3'd0) begin errors++; $display("FAIL reset_ctx got %b/%0d/%0d exp 0/0/0", in_service, active_irq, nest_depth); end
    checks++; if (iret_err !== 1'b0) begin errors++; $display("FAIL reset_iret_err got %b exp 0", iret_err); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic_entry();
    do_reset();
    int_enable = 1; insn_boundary = 1; cur_pc = 32'h1000;
    pulse_irq(32'h0000_0028);
    checks++; if (stall_core !== 1'b0 || vtbl_req !== 1'b0) begin errors++; $display("FAIL basic_take_cycle got stall %b req %b exp 0 0", stall_core, vtbl_req); end
    @(negedge clk);
    checks++; if (vtbl_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", vtbl_req); end
    checks++; if (vtbl_addr !== 32'h0000_010C) begin errors++; $display("FAIL basic_addr got %h exp 0000010c", vtbl_addr); end
    checks++; if (stall_core !== 1'b1) begin errors++; $display("FAIL basic_stall got %b exp 1", stall_core); end
    checks++; if (dut.pend_q !== 32'h0000_0020) begin errors++; $display("FAIL basic_pend got %h exp 00000020", dut.pend_q); end
    checks++; if (active_irq !== 5'd3 || nest_depth !== 3'd1 || in_service !== 1'b1) begin errors++; $display("FAIL basic_ctx got %0d/%0d/%b exp 3/1/1", active_irq, nest_depth, in_service); end
    repeat (3) @(negedge clk);
    checks++; if (vtbl_req !== 1'b1 || vtbl_addr !== 32'h0000_010C) begin errors++; $display("FAIL basic_req_hold got %b/%h exp 1/0000010c", vtbl_req, vtbl_addr); end
    vtbl_ack = 1; vtbl_data = 32'h0000_2003;
    @(negedge clk);
    vtbl_ack = 0; vtbl_data = 0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_2000) begin errors++; $display("FAIL basic_redirect got %b/%h exp 1/00002000", redirect_valid, redirect_pc); end
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0 || stall_core !== 1'b0) begin errors++; $display("FAIL basic_redirect_end got rv %b stall %b exp 0 0", redirect_valid, stall_core); end
    repeat (2) @(negedge clk);
    checks++; if (vtbl_req !== 1'b0 || nest_depth !== 3'd1) begin errors++; $display("FAIL basic_no_lower_take got req %b depth %0d exp 0 1", vtbl_req, nest_depth); end
  endtask

  task automatic test_preempt();
    bit got; logic [31:0] addr; logic rv; logic [31:0] rpc;
    do_reset();
    int_enable = 1; insn_boundary = 1; cur_pc = 32'h5000;
    pulse_irq(32'h0000_0020);
    fetch_ack(32'h0000_3000, got, addr, rv, rpc);
    checks++; if (!got || addr !== 32'h0000_0114) begin errors++; $display("FAIL pre_addr5 got %b/%h exp 1/00000114", got, addr); end
    checks++; if (rv !== 1'b1 || rpc !== 32'h0000_3000) begin errors++; $display("FAIL pre_redir5 got %b/%h exp 1/00003000", rv, rpc); end
    cur_pc = 32'h3010;
    pulse_irq(32'h0000_0001);
    fetch_ack(32'h0000_4001, got, addr, rv, rpc);
    checks++; if (!got || addr !== 32'h0000_0100) begin errors++; $display("FAIL pre_addr0 got %b/%h exp 1/00000100", got, addr); end
    checks++; if (rpc !== 32'h0000_4000) begin errors++; $display("FAIL pre_redir0 got %h exp 00004000", rpc); end
    checks++; if (nest_depth !== 3'd2 || active_irq !== 5'd0) begin errors++; $display("FAIL pre_nest got %0d/%0d exp 2/0", nest_depth, active_irq); end
    cur_pc = 32'h4100;
    pulse_irq(32'h0000_0040);
    repeat (3) @(negedge clk);
    checks++; if (vtbl_req !== 1'b0 || dut.pend_q !== 32'h0000_0040 || nest_depth !== 3'd2) begin errors++; $display("FAIL pre_no_take6 got req %b pend %h depth %0d exp 0 00000040 2", vtbl_req, dut.pend_q, nest_depth); end
    iret = 1;
    @(negedge clk);
    iret = 0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_3010 || stall_core !== 1'b1) begin errors++; $display("FAIL pre_iret_redir got %b/%h/%b exp 1/00003010/1", redirect_valid, redirect_pc, stall_core); end
    @(negedge clk);
    checks++; if (active_irq !== 5'd5 || nest_depth !== 3'd1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL pre_iret_pop got %0d/%0d/%b exp 5/1/0", active_irq, nest_depth, redirect_valid); end
    @(negedge clk);
    checks++; if (vtbl_req !== 1'b0 || dut.pend_q !== 32'h0000_0040) begin errors++; $display("FAIL pre_6_still_blocked got req %b pend %h exp 0 00000040", vtbl_req, dut.pend_q); end
  endtask

  task automatic test_stack_full();
    bit got; logic [31:0] addr; logic rv; logic [31:0] rpc;
    logic [31:0] vecs [4];
    logic [31:0] pcs  [4];
    vecs = '{32'h80, 32'h40, 32'h20, 32'h10};
    pcs  = '{32'h7770, 32'h6660, 32'h5550, 32'h4440};
    do_reset();
    int_enable = 1; insn_boundary = 1;
    for (int k = 0; k < 4; k++) begin
      cur_pc = pcs[k];
      pulse_irq(vecs[k]);
      fetch_ack(32'h0000_8000 + 32'(k) * 32'h100, got, addr, rv, rpc);
      checks++; if (!got || addr !== 32'h100 + 32'(7 - k) * 4) begin errors++; $display("FAIL full_fill_addr k=%0d got %b/%h exp 1/%h", k, got, addr, 32'h100 + 32'(7 - k) * 4); end
    end
    checks++; if (nest_depth !== 3'd4 || active_irq !== 5'd4) begin errors++; $display("FAIL full_depth got %0d/%0d exp 4/4", nest_depth, active_irq); end
    cur_pc = 32'h3330;
    pulse_irq(32'h0000_0001);
    repeat (3) @(negedge clk);
    checks++; if (vtbl_req !== 1'b0 || dut.pend_q !== 32'h1 || nest_depth !== 3'd4) begin errors++; $display("FAIL full_no_take got req %b pend %h depth %0d exp 0 00000001 4", vtbl_req, dut.pend_q, nest_depth); end
    iret = 1;
    @(negedge clk);
    iret = 0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4440) begin errors++; $display("FAIL full_iret_pc got %b/%h exp 1/00004440", redirect_valid, redirect_pc); end
    @(negedge clk);
    checks++; if (nest_depth !== 3'd3 || active_irq !== 5'd5) begin errors++; $display("FAIL full_after_pop got %0d/%0d exp 3/5", nest_depth, active_irq); end
    fetch_ack(32'h0000_6000, got, addr, rv, rpc);
    checks++; if (!got || addr !== 32'h100 || rpc !== 32'h6000) begin errors++; $display("FAIL full_take0 got %b/%h/%h exp 1/00000100/00006000", got, addr, rpc); end
    checks++; if (nest_depth !== 3'd4 || active_irq !== 5'd0 || dut.pend_q !== 32'h0) begin errors++; $display("FAIL full_take0_ctx got %0d/%0d/%h exp 4/0/0", nest_depth, active_irq, dut.pend_q); end
  endtask

  task automatic test_iret_err();
    do_reset();
    iret = 1;
    @(negedge clk);
    iret = 0;
    checks++; if (iret_err !== 1'b1) begin errors++; $display("FAIL ierr_pulse got %b exp 1", iret_err); end
    checks++; if (redirect_valid !== 1'b0 || stall_core !== 1'b0) begin errors++; $display("FAIL ierr_no_redirect got rv %b stall %b exp 0 0", redirect_valid, stall_core); end
    @(negedge clk);
    checks++; if (iret_err !== 1'b0 || redirect_valid !== 1'b0 || stall_core !== 1'b0) begin errors++; $display("FAIL ierr_end got %b/%b/%b exp 0/0/0", iret_err, redirect_valid, stall_core); end
  endtask

  task automatic test_int_enable();
    bit seen = 0;
    bit got; logic [31:0] addr; logic rv; logic [31:0] rpc;
    do_reset();
    int_enable = 0; insn_boundary = 1; cur_pc = 32'h9000;
    pulse_irq(32'h0000_0080);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vtbl_req !== 1'b0) seen = 1;
    end
    checks++; if (seen || dut.pend_q !== 32'h80) begin errors++; $display("FAIL ie_blocked got seen %b pend %h exp 0 00000080", seen, dut.pend_q); end
    insn_boundary = 0; int_enable = 1;
    repeat (2) @(negedge clk);
    checks++; if (vtbl_req !== 1'b0) begin errors++; $display("FAIL ie_no_boundary got %b exp 0", vtbl_req); end
    insn_boundary = 1;
    @(negedge clk);
    checks++; if (vtbl_req !== 1'b1 || vtbl_addr !== 32'h0000_011C) begin errors++; $display("FAIL ie_take7 got %b/%h exp 1/0000011c", vtbl_req, vtbl_addr); end
    fetch_ack(32'h0000_A002, got, addr, rv, rpc);
    checks++; if (rv !== 1'b1 || rpc !== 32'h0000_A000 || active_irq !== 5'd7) begin errors++; $display("FAIL ie_redirect got %b/%h/%0d exp 1/0000a000/7", rv, rpc, active_irq); end
  endtask

  task automatic test_back_to_back();
    bit got; logic [31:0] addr; logic rv; logic [31:0] rpc;
    do_reset();
    int_enable = 0; insn_boundary = 1; cur_pc = 32'hB000;
    pulse_irq(32'h0000_0008);
    int_enable = 1; irq_valid = 1; irq_vector = 32'h0000_0008;
    @(negedge clk);
    irq_valid = 0; irq_vector = 0;
    checks++; if (dut.pend_q !== 32'h8 || vtbl_req !== 1'b1 || vtbl_addr !== 32'h10C) begin errors++; $display("FAIL b2b_set_clear got pend %h req %b addr %h exp 00000008 1 0000010c", dut.pend_q, vtbl_req, vtbl_addr); end
    fetch_ack(32'h0000_C000, got, addr, rv, rpc);
    checks++; if (rpc !== 32'h0000_C000 || nest_depth !== 3'd1) begin errors++; $display("FAIL b2b_redirect got %h/%0d exp 0000c000/1", rpc, nest_depth); end
    repeat (2) @(negedge clk);
    checks++; if (vtbl_req !== 1'b0 || dut.pend_q !== 32'h8) begin errors++; $display("FAIL b2b_no_self_preempt got req %b pend %h exp 0 00000008", vtbl_req, dut.pend_q); end
  endtask

  task automatic test_reset_in_fetch();
    do_reset();
    int_enable = 1; insn_boundary = 1; cur_pc = 32'hD000;
    pulse_irq(32'h0000_0004);
    @(negedge clk);
    checks++; if (vtbl_req !== 1'b1) begin errors++; $display("FAIL rf_in_fetch got %b exp 1", vtbl_req); end
    #2 reset = 1;
    #1;
    checks++; if (vtbl_req !== 1'b0 || stall_core !== 1'b0) begin errors++; $display("FAIL rf_req_drop got req %b stall %b exp 0 0", vtbl_req, stall_core); end
    checks++; if (nest_depth !== 3'd0 || dut.pend_q !== 32'h0) begin errors++; $display("FAIL rf_cleared got depth %0d pend %h exp 0 0", nest_depth, dut.pend_q); end
    @(negedge clk);
    reset = 0;
    vtbl_ack = 1; vtbl_data = 32'h0000_E000;
    @(negedge clk);
    vtbl_ack = 0; vtbl_data = 0;
    checks++; if (redirect_valid !== 1'b0 || vtbl_req !== 1'b0) begin errors++; $display("FAIL rf_late_ack got rv %b req %b exp 0 0", redirect_valid, vtbl_req); end
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0 || stall_core !== 1'b0) begin errors++; $display("FAIL rf_late_ack2 got rv %b stall %b exp 0 0", redirect_valid, stall_core); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_basic_entry();
    test_preempt();
    test_stack_full();
    test_iret_err();
    test_int_enable();
    test_back_to_back();
    test_reset_in_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_entry_sequencer.md
Name: irq_entry_sequencer

Overview:
- CPU-side responder for the interrupt controller's ack/vector output.
- Latches the one-cycle ack pulse and pending mask, and picks the highest-priority source (lowest bit index).
- Waits for an instruction boundary, saves the PC on a nesting stack, reads the handler address from the vector table over a request/ack handshake, then redirects the core.
- Also executes return-from-interrupt (pop and redirect).

Parameters:
VTBL_BASE, 32'h0000_0100, byte address of vector table; entry n at VTBL_BASE + 4*n
NEST_DEPTH, 4, number of saved-context stack entries (power of two, 2..8)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
irq_valid  in  1  one-cycle pulse from interrupt controller (its ack)
irq_vector  in  32  pending mask accompanying irq_valid
int_enable  in  1  global interrupt enable from status register
insn_boundary  in  1  core may be redirected this cycle
cur_pc  in  32  PC of next instruction to execute
iret  in  1  core retiring return-from-interrupt, one-cycle pulse
vtbl_req  out  1  vector-table read request
vtbl_addr  out  32  vector-table read address
vtbl_ack  in  1  read complete; vtbl_data valid this cycle
vtbl_data  in  32  handler address
stall_core  out  1  hold core front end
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  32  redirect target
in_service  out  1  nesting depth != 0
active_irq  out  5  id at stack top; 0 when stack empty
nest_depth  out  $clog2(NEST_DEPTH)+1  current stack depth
iret_err  out  1  one-cycle pulse: iret with empty stack

Behaviour:
- Reset values:
  - All outputs 0.
  - Pending mask 0, stack empty, state IDLE.
  - An async reset during FETCH drops vtbl_req immediately; a late vtbl_ack after reset is ignored.
- Pending mask update each cycle: pend <= (pend & ~take_clr) | (irq_valid ? irq_vector : 0).
  - A set arriving in the same cycle as a take-clear of the same bit leaves that bit pending.
- Selection (combinational): sel_id = lowest set bit index of pend.
- Eligibility: depth==0, or sel_id < active_irq (strict preemption only).
- States: IDLE, FETCH, REDIRECT, RETURN.
- IDLE:
  - If iret: when depth>0, go to RETURN; otherwise pulse iret_err and stay. iret wins over take in the same cycle.
  - Else take when pend!=0 && int_enable && insn_boundary && eligible && depth<NEST_DEPTH. On take:
    - push {cur_pc, sel_id};
    - clear pend[sel_id];
    - next cycle enter FETCH.
  - Stack full: no take; bits stay pending.
- FETCH:
  - vtbl_req=1, vtbl_addr = VTBL_BASE + {sel_id_latched, 2'b00}, stable until vtbl_ack.
  - On vtbl_ack: capture vtbl_data & ~32'h3, go to REDIRECT.
  - Unbounded wait.
- REDIRECT: redirect_valid=1 for exactly one cycle with the handler address, then IDLE.
- RETURN:
  - redirect_valid=1, redirect_pc = stacked pc at top; pop.
  - active_irq becomes the new top id (0 if empty); then IDLE.
- stall_core=1 in FETCH, REDIRECT, RETURN; 0 in IDLE.
- Latency: take in cycle T -> vtbl_req in T+1 -> ack in cycle A -> redirect_valid in A+1.
- irq_valid is accepted in every state; the mask is never lost.
- in_service and active_irq update in the cycle after the push or pop.
- iret pulses outside IDLE are ignored. The core guarantees none occur while stall_core=1.

Decomposition:
- Shared package irq_pkg:
  - IRQ_ID_W=5, NUM_IRQ=32;
  - state enum {IDLE, FETCH, REDIRECT, RETURN};
  - vector-entry size constant 4.
- Sub-module irq_ctx_stack: LIFO of {pc[31:0], id[4:0]} with push, pop, top, depth, full and empty.
  - Push and pop in the same cycle are never requested.

Test Plan:
- irq_valid pulse with irq_vector=32'h0000_0028, int_enable=1, insn_boundary=1, cur_pc=32'h1000:
  - take id 3; vtbl_addr=32'h10C;
  - vtbl_data=32'h2003 -> redirect_pc=32'h2000;
  - active_irq=3; pend=32'h20.
- During id 5 service, pulse vector 32'h1 -> preempts: depth=2, active_irq=0. Pulse vector 32'h40 -> no take, pend[6]=1. iret -> redirect to the saved PC; active_irq=5.
- Fill the stack with ids 7,6,5,4 (NEST_DEPTH=4), then pulse vector 32'h1 -> no take, pend[0]=1; after one iret, id 0 is taken.
- iret with depth=0 -> iret_err pulses for 1 cycle; no redirect_valid; state stays IDLE.
- int_enable=0 with a pending vector 32'h80 for 10 cycles -> no vtbl_req. Raise int_enable -> take id 7 on the next boundary.
- Assert reset while in FETCH with vtbl_req=1 -> vtbl_req=0 immediately; a later vtbl_ack produces no redirect; pend=0 and depth=0.
